// File: rtl/cadeado_ctrl.sv
// Combination-lock controller: synchronises four push-buttons, checks the press
// sequence against CODE, drives the lock, counts failures and enforces a lockout.
//
// state        | meaning
// ST_ENTRADA   | collecting digits of an attempt
// ST_ABERTO    | lock open, auto-relock after OPEN_CYCLES or on lock_cmd
// ST_BLOQUEADO | lockout after MAX_TRIES failures, all input ignored
module cadeado_ctrl #(
  parameter int                    CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0] CODE           = 8'hD8,
  parameter int                    MAX_TRIES      = 3,
  parameter int                    OPEN_CYCLES    = 500,
  parameter int                    LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic       lock_cmd,
  output logic       aberto,
  output logic       bloqueado,
  output logic       erro,
  output logic [3:0] falhas,
  output logic [3:0] progresso
);

  localparam int MAX_CYC = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [3:0]    LAST_IDX  = 4'(CODE_LEN - 1);
  localparam logic [3:0]    MAX_F     = 4'(MAX_TRIES);

  typedef enum logic [1:0] {ST_ENTRADA, ST_ABERTO, ST_BLOQUEADO} state_t;

  state_t        state, state_nx;
  logic [3:0]    btn_s1, btn_s2, btn_prev;
  logic [3:0]    press;
  logic          press_any, press_multi, digit_bad;
  logic [1:0]    digit, code_digit;
  logic [3:0]    idx, idx_nx;
  logic          mismatch, mismatch_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [3:0]    falhas_q, falhas_nx;
  logic          erro_q, erro_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '0;
    end else begin
      btn_s1   <= btn;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
    end
  end

  assign press       = btn_s2 & ~btn_prev;
  assign press_any   = |press;
  assign press_multi = |(press & (press - 4'd1));

  // Multi-button presses always count as a mismatch, so the encoder priority is irrelevant.
  always_comb begin
    digit = 2'd0;
    if (press[1]) digit = 2'd1;
    if (press[2]) digit = 2'd2;
    if (press[3]) digit = 2'd3;
    code_digit = 2'd0;
    for (int i = 0; i < CODE_LEN; i++)
      if (idx == 4'(i)) code_digit = CODE[2*i +: 2];
  end

  assign digit_bad = press_multi | (digit != code_digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_ENTRADA;
      idx      <= '0;
      mismatch <= 1'b0;
      timer    <= '0;
      falhas_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      mismatch <= mismatch_nx;
      timer    <= timer_nx;
      falhas_q <= falhas_nx;
      erro_q   <= erro_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    mismatch_nx = mismatch;
    timer_nx    = timer;
    falhas_nx   = falhas_q;
    erro_nx     = 1'b0;
    case (state)
      ST_ENTRADA: begin
        if (lock_cmd) begin
          idx_nx      = '0;
          mismatch_nx = 1'b0;
        end else if (press_any) begin
          if (idx == LAST_IDX) begin
            idx_nx      = '0;
            mismatch_nx = 1'b0;
            timer_nx    = '0;
            if (!(mismatch | digit_bad)) begin
              state_nx  = ST_ABERTO;
              falhas_nx = '0;
            end else begin
              erro_nx   = 1'b1;
              falhas_nx = (falhas_q >= MAX_F) ? falhas_q : falhas_q + 4'd1;
              if (falhas_q + 4'd1 == MAX_F) state_nx = ST_BLOQUEADO;
            end
          end else begin
            idx_nx      = idx + 4'd1;
            mismatch_nx = mismatch | digit_bad;
          end
        end
      end
      ST_ABERTO: begin
        if (lock_cmd || timer == OPEN_LAST) begin
          state_nx = ST_ENTRADA;
          timer_nx = '0;
        end else begin
          timer_nx = timer + T_ONE;
        end
      end
      ST_BLOQUEADO: begin
        if (timer == LOCK_LAST) begin
          state_nx  = ST_ENTRADA;
          timer_nx  = '0;
          falhas_nx = '0;
        end else begin
          timer_nx = timer + T_ONE;
        end
      end
      default: state_nx = ST_ENTRADA;
    endcase
  end

  assign aberto    = (state == ST_ABERTO);
  assign bloqueado = (state == ST_BLOQUEADO);
  assign erro      = erro_q;
  assign falhas    = falhas_q;
  assign progresso = idx;

endmodule

// File: tb/tb_cadeado_ctrl.sv
// Bench for cadeado_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all outputs compared every cycle against a behavioural model.
module tb_cadeado_ctrl;

  localparam int CODE_LEN = 4;
  localparam int CODE_I   = 'hD8;
  localparam int MAX_T    = 3;
  localparam int OPEN_C   = 8;
  localparam int LOCK_C   = 16;
  localparam logic [3:0] A = 4'b0001, B = 4'b0010, C = 4'b0100, D = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       lock_cmd = 1'b0;
  logic       aberto, bloqueado, erro;
  logic [3:0] falhas, progresso;

  cadeado_ctrl #(
    .CODE_LEN(CODE_LEN), .CODE(8'hD8), .MAX_TRIES(MAX_T),
    .OPEN_CYCLES(OPEN_C), .LOCKOUT_CYCLES(LOCK_C)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .lock_cmd(lock_cmd),
    .aberto(aberto), .bloqueado(bloqueado), .erro(erro),
    .falhas(falhas), .progresso(progresso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int erro_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = entering, 1 = open, 2 = lockout; m_rem counts remaining cycles.
  int m_mode = 0, m_cnt = 0, m_bad = 0, m_rem = 0, m_fails = 0, m_erro = 0;
  logic [3:0] h0 = 0, h1 = 0, h2 = 0;

  function automatic int want_digit(input int pos);
    return (CODE_I >> (2 * pos)) & 3;
  endfunction

  initial begin
    logic [3:0] p;
    logic       lc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_cnt = 0; m_bad = 0; m_rem = 0; m_fails = 0; m_erro = 0;
        h0 = 0; h1 = 0; h2 = 0;
      end else begin
        // A press reaches the controller two edges after the raw rise is first sampled.
        p  = h1 & ~h2;
        h2 = h1; h1 = h0; h0 = btn;
        lc = lock_cmd;
        m_erro = 0;
        case (m_mode)
          0: begin
            if (lc) begin
              m_cnt = 0; m_bad = 0;
            end else if (p != 0) begin
              if (p != 4'(1 << want_digit(m_cnt))) m_bad = 1;
              m_cnt++;
              if (m_cnt == CODE_LEN) begin
                m_cnt = 0;
                if (m_bad == 0) begin
                  m_mode = 1; m_rem = OPEN_C; m_fails = 0;
                end else begin
                  m_erro = 1;
                  if (m_fails < MAX_T) m_fails++;
                  if (m_fails == MAX_T) begin
                    m_mode = 2; m_rem = LOCK_C;
                  end
                end
                m_bad = 0;
              end
            end
          end
          1: begin
            m_rem--;
            if (lc || m_rem == 0) m_mode = 0;
          end
          default: begin
            m_rem--;
            if (m_rem == 0) begin
              m_mode = 0; m_fails = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (erro) erro_cnt++;
      chk("cmp_aberto",    aberto,    m_mode == 1);
      chk("cmp_bloqueado", bloqueado, m_mode == 2);
      chk("cmp_erro",      erro,      m_erro);
      chk("cmp_falhas",    falhas,    m_fails);
      chk("cmp_progresso", progresso, m_cnt);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  task automatic press(input logic [3:0] v);
    btn = v;
    repeat (4) @(negedge clk);
    btn = 4'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic enter(input logic [3:0] d0, d1, d2, d3);
    press(d0); press(d1); press(d2); press(d3);
  endtask

  task automatic wait_open(input string name);
    int n = 0;
    while (!aberto && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, aberto, 1);
  endtask

  task automatic wait_lock(input string name);
    int n = 0;
    while (!bloqueado && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, bloqueado, 1);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {aberto, bloqueado, erro, falhas, progresso}, 0);
  endtask

  initial begin
    int cnt, e0, hold;
    logic [3:0] v;

    #1 chk_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Correct code: open exactly three edges after d is driven, for OPEN_C cycles.
    press(A); press(C); press(B);
    btn = D;
    @(negedge clk); @(negedge clk);
    chk("t1_not_yet_open", aberto, 0);
    @(negedge clk);
    chk("t1_open", aberto, 1);
    cnt = 1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 0) btn = 4'd0;
      if (aberto) cnt++;
    end
    chk("t1_open_len", cnt, 8);
    chk("t1_falhas", falhas, 0);
    chk("t1_no_erro", erro_cnt, 0);
    chk("t1_model_mode", m_mode, 0);

    e0 = erro_cnt;
    enter(A, C, D, B);
    chk("t2_erro_pulse", erro_cnt - e0, 1);
    chk("t2_falhas", falhas, 1);
    chk("t2_aberto", aberto, 0);
    chk("t2_progresso", progresso, 0);

    e0 = erro_cnt;
    enter(A | B, C, B, D);
    chk("t4_erro_pulse", erro_cnt - e0, 1);
    chk("t4_falhas", falhas, 2);

    // Third failure locks out; presses and lock_cmd during lockout are ignored.
    press(A); press(C); press(D);
    btn = B;
    wait_lock("t3_lock");
    chk("t3_falhas_sat", falhas, 3);
    chk("t3_model_mode", m_mode, 2);
    cnt = 1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 1) btn = 4'd0;
      if (i == 4) btn = A;
      if (i == 7) btn = 4'd0;
      if (i == 9) lock_cmd = 1'b1;
      if (i == 10) lock_cmd = 1'b0;
      if (bloqueado) cnt++;
    end
    chk("t3_lock_len", cnt, 16);
    chk("t3_progresso", progresso, 0);
    chk("t3_falhas_clear", falhas, 0);
    enter(A, C, B, D);
    chk("t3_reopen", aberto, 1);
    repeat (6) @(negedge clk);

    // lock_cmd in the third open cycle closes on the next edge.
    press(A); press(C); press(B);
    btn = D;
    wait_open("t5_open");
    @(negedge clk); @(negedge clk);
    lock_cmd = 1'b1;
    @(negedge clk);
    chk("t5_closed", aberto, 0);
    lock_cmd = 1'b0;
    btn = 4'd0;
    repeat (4) @(negedge clk);
    press(A); press(C);
    chk("t5_partial", progresso, 2);
    lock_cmd = 1'b1;
    @(negedge clk);
    lock_cmd = 1'b0;
    chk("t5_abandon", progresso, 0);
    chk("t5_falhas", falhas, 0);
    @(negedge clk);

    // Asynchronous reset mid-attempt and mid-lockout.
    press(A); press(C);
    chk("t6_partial", progresso, 2);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_reset_entry");
    @(negedge clk);
    rst_n = 1'b1;
    enter(A, C, B, D);
    chk("t6_open_after", aberto, 1);
    repeat (6) @(negedge clk);
    enter(B, B, B, B);
    enter(D, D, D, D);
    enter(C, A, B, D);
    chk("t6_locked", bloqueado, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("t6_reset_lock");
    @(negedge clk);
    rst_n = 1'b1;
    enter(A, C, B, D);
    chk("t6_open_after_lock", aberto, 1);
    repeat (6) @(negedge clk);

    // Randomized stimulus, biased towards the expected next digit.
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: v = 4'(1 << want_digit(m_cnt));
        4, 5, 6, 7: v = 4'(1 << $urandom_range(0, 3));
        8:          v = 4'($urandom_range(0, 15));
        default:    v = 4'd0;
      endcase
      btn = v;
      lock_cmd = ($urandom_range(0, 19) == 0);
      hold = $urandom_range(1, 5);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        lock_cmd = 1'b0;
      end
      btn = 4'd0;
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
